// File: rtl/id_pkg.sv
// Shared decode definitions: opcode/funct constants, ALU op encoding and the
// decoded-bundle struct that travels through the output/skid registers.
package id_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_SLL = 2'd2
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    alu_op_e     aluOp;
    logic        aluSrcImm;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        branch;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/id_immGen.sv
// Immediate generator: picks I/S/B format from the opcode and sign-extends
// from instr[31]. Opcodes without an immediate yield zero.
module id_immGen
  import id_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm
);

  // rs1/funct3 field never feeds an immediate in the supported formats
  logic unused_fields;
  assign unused_fields = ^i_instr[19:12];

  // Format select on opcode only; funct legality is the decoder's problem
  always_comb begin
    o_imm = '0;
    case (i_instr[6:0])
      OPC_OPIMM, OPC_LOAD: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      OPC_STORE:           o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OPC_BRANCH:          o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                    i_instr[30:25], i_instr[11:8], 1'b0};
      default:             o_imm = '0;
    endcase
  end

endmodule

// File: rtl/id_decode.sv
// RV32I subset decode stage. Decodes combinationally, then buffers the
// decoded bundle in an output register plus one skid register so that the
// registered o_ready never drops an instruction.
module id_decode
  import id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_flush,
  input  logic            i_ready,
  output logic            o_valid,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_imm,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [1:0]      o_aluOp,
  output logic            o_aluSrcImm,
  output logic            o_regWrite,
  output logic            o_memRead,
  output logic            o_memWrite,
  output logic            o_branch,
  output logic            o_illegal
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

  state_e      state_q;
  dec_t        out_q, skid_q, dec_d;
  logic        valid_q, ready_q;
  logic [31:0] imm;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;

  assign opc = i_instr[6:0];
  assign f3  = i_instr[14:12];
  assign f7  = i_instr[31:25];

  id_immGen u_immGen (.i_instr(i_instr), .o_imm(imm));

  // Decode: start from "illegal, raw fields" and clear illegal on a match
  always_comb begin
    dec_d           = '0;
    dec_d.pc        = i_pc;
    dec_d.imm       = imm;
    dec_d.rd        = i_instr[11:7];
    dec_d.rs1       = i_instr[19:15];
    dec_d.rs2       = i_instr[24:20];
    dec_d.aluOp     = ALU_ADD;
    dec_d.illegal   = 1'b1;
    case (opc)
      OPC_OP: begin
        if (f3 == F3_ADD && f7 == F7_BASE) begin
          dec_d.illegal = 1'b0; dec_d.regWrite = 1'b1;
        end else if (f3 == F3_ADD && f7 == F7_ALT) begin
          dec_d.illegal = 1'b0; dec_d.regWrite = 1'b1; dec_d.aluOp = ALU_SUB;
        end else if (f3 == F3_SLL && f7 == F7_BASE) begin
          dec_d.illegal = 1'b0; dec_d.regWrite = 1'b1; dec_d.aluOp = ALU_SLL;
        end
      end
      OPC_OPIMM: if (f3 == F3_ADD) begin
        dec_d.illegal = 1'b0; dec_d.regWrite = 1'b1; dec_d.aluSrcImm = 1'b1;
      end
      OPC_LOAD: if (f3 == F3_WORD) begin
        dec_d.illegal = 1'b0; dec_d.regWrite = 1'b1; dec_d.memRead = 1'b1;
        dec_d.aluSrcImm = 1'b1;
      end
      OPC_STORE: if (f3 == F3_WORD) begin
        dec_d.illegal = 1'b0; dec_d.memWrite = 1'b1; dec_d.aluSrcImm = 1'b1;
      end
      OPC_BRANCH: if (f3 == F3_ADD) begin
        dec_d.illegal = 1'b0; dec_d.branch = 1'b1; dec_d.aluOp = ALU_SUB;
      end
      default: ;
    endcase
  end

  // Skid FSM: reset > flush > handshake; ready_q tracks "next state != FULL"
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else if (i_flush) begin
      state_q <= S_EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        S_EMPTY: if (i_valid) begin
          out_q   <= dec_d;
          valid_q <= 1'b1;
          state_q <= S_ONE;
        end
        S_ONE: begin
          if (i_valid && !i_ready) begin
            skid_q  <= dec_d;
            ready_q <= 1'b0;
            state_q <= S_FULL;
          end else if (i_valid && i_ready) begin
            out_q   <= dec_d;
          end else if (i_ready) begin
            valid_q <= 1'b0;
            state_q <= S_EMPTY;
          end
        end
        S_FULL: if (i_ready) begin
          out_q   <= skid_q;
          ready_q <= 1'b1;
          state_q <= S_ONE;
        end
        default: begin
          state_q <= S_EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready     = ready_q;
  assign o_valid     = valid_q;
  assign o_pc        = out_q.pc;
  assign o_imm       = out_q.imm;
  assign o_rd        = out_q.rd;
  assign o_rs1       = out_q.rs1;
  assign o_rs2       = out_q.rs2;
  assign o_aluOp     = out_q.aluOp;
  assign o_aluSrcImm = out_q.aluSrcImm;
  assign o_regWrite  = out_q.regWrite;
  assign o_memRead   = out_q.memRead;
  assign o_memWrite  = out_q.memWrite;
  assign o_branch    = out_q.branch;
  assign o_illegal   = out_q.illegal;

endmodule

// File: tb/tb_id_decode.sv
// Directed bench for id_decode: decode table streamed back-to-back, then
// skid fill/drain, flush from FULL, and reset mid-stream.
module tb_id_decode;

  logic        clk = 1'b0;
  logic        rst, vld, flush, rdy_in;
  logic [31:0] instr, pc;
  logic        o_ready, o_valid;
  logic [31:0] o_pc, o_imm;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic [1:0]  o_aluOp;
  logic        o_aluSrcImm, o_regWrite, o_memRead, o_memWrite, o_branch, o_illegal;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  id_decode #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .o_ready(o_ready),
    .i_instr(instr), .i_pc(pc), .i_flush(flush), .i_ready(rdy_in),
    .o_valid(o_valid), .o_pc(o_pc), .o_imm(o_imm),
    .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_aluOp(o_aluOp),
    .o_aluSrcImm(o_aluSrcImm), .o_regWrite(o_regWrite), .o_memRead(o_memRead),
    .o_memWrite(o_memWrite), .o_branch(o_branch), .o_illegal(o_illegal)
  );

  // flags: {aluSrcImm, regWrite, memRead, memWrite, branch, illegal}
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [1:0]  alu;
    logic [5:0]  fl;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic [31:0] ins, logic [31:0] p, logic [31:0] im,
                              logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                              logic [1:0] a, logic [5:0] f);
    vec_t v;
    v.instr = ins; v.pc = p; v.imm = im; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.alu = a; v.fl = f;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] flags();
    return {o_aluSrcImm, o_regWrite, o_memRead, o_memWrite, o_branch, o_illegal};
  endfunction

  task automatic chk_bundle(input string tag, input vec_t v);
    chk({tag, ".valid"}, {31'd0, o_valid}, 32'd1);
    chk({tag, ".pc"},    o_pc, v.pc);
    chk({tag, ".imm"},   o_imm, v.imm);
    chk({tag, ".rd"},    {27'd0, o_rd},  {27'd0, v.rd});
    chk({tag, ".rs1"},   {27'd0, o_rs1}, {27'd0, v.rs1});
    chk({tag, ".rs2"},   {27'd0, o_rs2}, {27'd0, v.rs2});
    chk({tag, ".aluOp"}, {30'd0, o_aluOp}, {30'd0, v.alu});
    chk({tag, ".flags"}, {26'd0, flags()}, {26'd0, v.fl});
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p);
    @(negedge clk);
    vld = v; instr = ins; pc = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t sk;

  initial begin
    rst = 1'b1; vld = 1'b0; flush = 1'b0; rdy_in = 1'b1; instr = '0; pc = '0;

    vecs[0]  = mk(32'h00108093, 32'h100, 32'h00000001,  1,  1,  1, 2'd0, 6'b110000); // ADDI x1,x1,1
    vecs[1]  = mk(32'hFE0086E3, 32'h104, 32'hFFFFFFEC, 13,  1,  0, 2'd1, 6'b000010); // BEQ x1,x0,-20
    vecs[2]  = mk(32'h00912223, 32'h108, 32'h00000004,  4,  2,  9, 2'd0, 6'b100100); // SW x9,4(x2)
    vecs[3]  = mk(32'h00412503, 32'h10C, 32'h00000004, 10,  2,  4, 2'd0, 6'b111000); // LW x10,4(x2)
    vecs[4]  = mk(32'h002081B3, 32'h110, 32'h00000000,  3,  1,  2, 2'd0, 6'b010000); // ADD x3,x1,x2
    vecs[5]  = mk(32'h408484B3, 32'h114, 32'h00000000,  9,  9,  8, 2'd1, 6'b010000); // SUB x9,x9,x8
    vecs[6]  = mk(32'h002091B3, 32'h118, 32'h00000000,  3,  1,  2, 2'd2, 6'b010000); // SLL x3,x1,x2
    vecs[7]  = mk(32'hFFFFFFFF, 32'h11C, 32'h00000000, 31, 31, 31, 2'd0, 6'b000001); // illegal opcode
    vecs[8]  = mk(32'h022081B3, 32'h120, 32'h00000000,  3,  1,  2, 2'd0, 6'b000001); // MUL: bad funct7
    vecs[9]  = mk(32'hFFF00093, 32'h124, 32'hFFFFFFFF,  1,  0, 31, 2'd0, 6'b110000); // ADDI x1,x0,-1
    vecs[10] = mk(32'h00010503, 32'h128, 32'h00000000, 10,  2,  0, 2'd0, 6'b000001); // LB: bad funct3

    // Reset: outputs cleared and ready while reset is held
    tick(); tick();
    chk("rst.valid", {31'd0, o_valid}, 32'd0);
    chk("rst.ready", {31'd0, o_ready}, 32'd1);
    chk("rst.pc",    o_pc, 32'd0);
    chk("rst.flags", {26'd0, flags()}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Table streamed back-to-back with EX always ready (ONE: accept+ready)
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].pc);
      tick();
      chk_bundle($sformatf("vec%0d", i), vecs[i]);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("drain.valid", {31'd0, o_valid}, 32'd0);
    chk("drain.ready", {31'd0, o_ready}, 32'd1);

    // Skid: EX stalled while three SUBs are offered; only two fit
    sk = vecs[5];
    @(negedge clk); rdy_in = 1'b0; vld = 1'b1; instr = sk.instr; pc = 32'h200;
    tick();
    @(negedge clk); pc = 32'h204;
    tick();
    chk("skid.full.ready", {31'd0, o_ready}, 32'd0);
    sk.pc = 32'h200; chk_bundle("skid.hold1", sk);
    @(negedge clk); pc = 32'h208;
    tick();
    chk("skid.stay.ready", {31'd0, o_ready}, 32'd0);
    chk_bundle("skid.hold2", sk);
    @(negedge clk); vld = 1'b0; rdy_in = 1'b1;
    tick();
    sk.pc = 32'h204; chk_bundle("skid.second", sk);
    chk("skid.second.ready", {31'd0, o_ready}, 32'd1);
    tick();
    chk("skid.empty.valid", {31'd0, o_valid}, 32'd0);

    // Flush from FULL with a new instruction offered in the same cycle
    @(negedge clk); rdy_in = 1'b0; vld = 1'b1; instr = vecs[0].instr; pc = 32'h300;
    tick();
    @(negedge clk); pc = 32'h304;
    tick();
    chk("flush.pre.ready", {31'd0, o_ready}, 32'd0);
    @(negedge clk); flush = 1'b1; pc = 32'h308;
    tick();
    chk("flush.valid", {31'd0, o_valid}, 32'd0);
    chk("flush.ready", {31'd0, o_ready}, 32'd1);
    @(negedge clk); flush = 1'b0; vld = 1'b0; rdy_in = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("flush.quiet%0d", c), {31'd0, o_valid}, 32'd0);
    end

    // Illegal instruction held, then reset mid-stream
    drive(1'b1, vecs[7].instr, 32'h400);
    @(negedge clk); vld = 1'b1; rdy_in = 1'b0;
    sk = vecs[7]; sk.pc = 32'h400;
    chk_bundle("ill.held", sk);
    @(negedge clk); rst = 1'b1; flush = 1'b1; instr = vecs[1].instr; pc = 32'h404;
    tick();
    chk("rst2.valid", {31'd0, o_valid}, 32'd0);
    chk("rst2.ready", {31'd0, o_ready}, 32'd1);
    chk("rst2.pc",    o_pc, 32'd0);
    chk("rst2.imm",   o_imm, 32'd0);
    chk("rst2.rd",    {27'd0, o_rd}, 32'd0);
    chk("rst2.flags", {26'd0, flags()}, 32'd0);
    @(negedge clk); rst = 1'b0; flush = 1'b0; vld = 1'b0; rdy_in = 1'b1;
    tick();
    chk("post.valid", {31'd0, o_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/id_decode.md
ID_DECODE -- requirements
Module: id_decode

Interface
REQ-001 Parameter XLEN, default 32, datapath width of PC and immediate; only 32 is supported.
REQ-002 i_clk  input  1  single clock; all state updates on posedge.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 i_valid  input  1  IF presents an instruction this cycle.
REQ-005 o_ready  output  1  stage can accept an instruction; registered.
REQ-006 i_instr  input  32  raw RV32I instruction word.
REQ-007 i_pc  input  32  PC of i_instr.
REQ-008 i_flush  input  1  branch taken; discard all held and incoming instructions.
REQ-009 i_ready  input  1  EX stage accepts o_* this cycle.
REQ-010 o_valid  output  1  decoded bundle valid.
REQ-011 o_pc, o_imm  output  32 each  PC; sign-extended immediate.
REQ-012 o_rd, o_rs1, o_rs2  output  5 each  register indices.
REQ-013 o_aluOp  output  2  ALU_ADD=0, ALU_SUB=1, ALU_SLL=2.
REQ-014 o_aluSrcImm, o_regWrite, o_memRead, o_memWrite, o_branch, o_illegal  output  1 each  control flags.

Function
REQ-015 Decode: opcode 0110011 f3 000 f7 0000000 -> ADD; f3 000 f7 0100000 -> SUB; f3 001 f7 0000000 -> SLL; 0010011 f3 000 -> ADDI; 1100011 f3 000 -> BEQ; 0100011 f3 010 -> SW; 0000011 f3 010 -> LW.
REQ-016 Controls: R-type regWrite=1; ADDI regWrite=1, aluSrcImm=1, ADD; LW regWrite=1, memRead=1, aluSrcImm=1, ADD; SW memWrite=1, aluSrcImm=1, ADD; BEQ branch=1, SUB.
REQ-017 Immediates: I-type instr[31:20]; S-type {instr[31:25],instr[11:7]}; B-type {instr[31],instr[7],instr[30:25],instr[11:8],0}; all sign-extended from bit 31; R-type imm=0.
REQ-018 Any other encoding: o_illegal=1, all other control flags 0, o_valid still asserted, fields passed raw.
REQ-019 Latency: one cycle from accepted input (i_valid && o_ready) to o_valid.
REQ-020 Buffering: 2-entry skid; FSM states EMPTY, ONE (output reg valid), FULL (output + skid valid).
REQ-021 EMPTY: accept -> ONE.  ONE: accept without i_ready -> FULL; i_ready without accept -> EMPTY; both or neither -> ONE.
REQ-022 FULL: o_ready=0; i_ready -> skid moves to output, ONE; else hold.
REQ-023 o_ready = 1 in EMPTY and ONE, 0 in FULL; no instruction lost or duplicated under any i_valid/i_ready pattern.
REQ-024 o_* stable while o_valid && !i_ready.
REQ-025 i_flush has priority over everything: next state EMPTY, o_valid=0 next cycle, input presented that cycle dropped.
REQ-026 Decode happens before the skid register, so skid holds decoded bundles.

Reset
REQ-027 i_rst -> state EMPTY, o_valid=0, all o_* data/control 0, o_ready=1 the cycle after reset; reset mid-operation discards held instructions.
REQ-028 Reset has priority over i_flush and handshakes.

Structure
REQ-029 Shared package id_pkg: opcode/funct3/funct7 constants, aluOp enum, decoded-bundle struct.
REQ-030 One sub-module id_immGen: combinational instruction-to-immediate generator, format selected by opcode.

Verification
REQ-031 Send 0x00108093 (ADDI x1,x1,1), i_ready=1 -> next cycle o_valid=1, rd=1, rs1=1, imm=1, regWrite=1, aluSrcImm=1.
REQ-032 Send 0xFE0086E3 (BEQ x1,x0,-20) -> branch=1, aluOp=SUB, rs1=1, rs2=0, imm=0xFFFFFFEC.
REQ-033 Send 0x00912223 (SW) then 0x00412503 (LW) -> memWrite=1 rs1=2 rs2=9 imm=4; then memRead=1 rd=10 imm=4.
REQ-034 Stream 0x408484B3 with i_ready=0 for 3 cycles -> FULL after 2 accepts, o_ready=0, output stable; release -> both emerge in order, no loss.
REQ-035 FULL state + i_flush=1 with i_valid=1 -> next cycle o_valid=0, o_ready=1, no bundle ever emitted for flushed inputs.
REQ-036 Send 0xFFFFFFFF -> o_illegal=1, o_valid=1, all other control flags 0; assert i_rst mid-stream -> all outputs 0 next cycle.
